// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first,
// operands accepted via start/busy, result presented with a done strobe.

module half_adder_behavioural (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] res_shift;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hs0, hc0, hc1;
    logic             fa_s, fa_c;
    logic             last_bit;

    half_adder_behavioural u_ha0 (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .sum   (hs0),
        .carry (hc0)
    );

    half_adder_behavioural u_ha1 (
        .a     (hs0),
        .b     (carry_q),
        .sum   (fa_s),
        .carry (hc1)
    );

    assign fa_c = hc0 | hc1;

    // A one-bit result has nothing to shift down; the new bit is the whole word.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = fa_s;
        end else begin : g_res_wn
            assign res_shift = {fa_s, res_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (state_q == ADD) && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ADD;
            ADD:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ADD);
        done = (state_q == DONE);
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            ADD: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = res_shift;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d  = res_shift;
                    cout_d = fa_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 8, 1 and 13 against a cycle-count
// arithmetic model, plus directed literal expectations.

module tb_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st[3];
    logic [12:0] av[3], bv[3];
    int          wd[3] = '{8, 1, 13};

    logic        busy8, done8, c8;
    logic [7:0]  s8;
    logic        busy1, done1, c1;
    logic [0:0]  s1;
    logic        busy13, done13, c13;
    logic [12:0] s13;

    logic [12:0] so[3];
    logic        bo[3], dno[3], coo[3];

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]),
        .busy(busy8), .done(done8), .sum(s8), .carry_out(c8)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]),
        .a(av[1][0:0]), .b(bv[1][0:0]),
        .busy(busy1), .done(done1), .sum(s1), .carry_out(c1)
    );

    serial_adder #(.WIDTH(13)) u13 (
        .clk(clk), .rst_n(rst_n), .start(st[2]),
        .a(av[2]), .b(bv[2]),
        .busy(busy13), .done(done13), .sum(s13), .carry_out(c13)
    );

    always_comb begin
        so[0]  = {5'd0, s8};
        so[1]  = {12'd0, s1};
        so[2]  = s13;
        bo[0]  = busy8;
        bo[1]  = busy1;
        bo[2]  = busy13;
        dno[0] = done8;
        dno[1] = done1;
        dno[2] = done13;
        coo[0] = c8;
        coo[1] = c1;
        coo[2] = c13;
    end

    function automatic int msk(int w);
        return (1 << w) - 1;
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, i, got, want);
        end
    endtask

    // Model: k = edges since acceptance (-1 when idle); the result is a+b.
    int k[3]  = '{-1, -1, -1};
    int es[3] = '{0, 0, 0};
    int ec[3] = '{0, 0, 0};
    int pend[3];
    bit armed = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                k[i]  = -1;
                es[i] = 0;
                ec[i] = 0;
            end else if (k[i] < 0) begin
                if (st[i]) begin
                    k[i] = 0;
                    pend[i] = (int'(av[i]) & msk(wd[i]))
                            + (int'(bv[i]) & msk(wd[i]));
                end
            end else begin
                k[i]++;
                if (k[i] == wd[i]) begin
                    es[i] = pend[i] & msk(wd[i]);
                    ec[i] = pend[i] >> wd[i];
                end else if (k[i] > wd[i]) begin
                    k[i] = -1;
                end
            end
        end
        if (!rst_n) armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                chk("busy", i, 32'(bo[i]), 32'(k[i] >= 0 && k[i] < wd[i]));
                chk("done", i, 32'(dno[i]), 32'(k[i] == wd[i]));
                chk("sum", i, 32'(so[i]), es[i]);
                chk("cout", i, 32'(coo[i]), ec[i]);
                chk("excl", i, 32'(bo[i] & dno[i]), 32'(0));
            end
        end
    end

    task automatic wait_idle(input int i);
        int n = 0;
        while ((bo[i] || dno[i]) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("idle_timeout", i, 32'(1), 32'(0));
    endtask

    task automatic op(input int i, input int a, input int b,
                      output int s, output int c, output int lat);
        wait_idle(i);
        av[i] = 13'(a);
        bv[i] = 13'(b);
        st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
        av[i] = 13'($urandom);
        bv[i] = 13'($urandom);
        lat = 0;
        while (!dno[i] && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 60) chk("done_timeout", i, 32'(1), 32'(0));
        s = int'(so[i]);
        c = int'(coo[i]);
    endtask

    task automatic rand_run(input int i);
        int a, b, s, c, lat;
        repeat (1000) begin
            a = int'($urandom) & msk(wd[i]);
            b = int'($urandom) & msk(wd[i]);
            op(i, a, b, s, c, lat);
            chk("rand_sum", i, (c << wd[i]) | s, a + b);
            chk("rand_lat", i, lat, wd[i]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        int s, c, lat, nd, last;
        int w1a[4] = '{0, 0, 1, 1};
        int w1b[4] = '{0, 1, 0, 1};
        int w1e[4] = '{0, 1, 1, 2};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            av[i] = '0;
            bv[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", 0, 32'(busy8), 32'(0));
            chk("rst_done", 0, 32'(done8), 32'(0));
            chk("rst_sum", 0, 32'(s8), 32'(0));
            chk("rst_cout", 0, 32'(c8), 32'(0));
        end

        op(0, 'h5A, 'h3C, s, c, lat);
        chk("lat_5a3c", 0, lat, 8);
        chk("sum_5a3c", 0, s, 'h96);
        chk("cout_5a3c", 0, c, 0);
        op(0, 'hFF, 'h01, s, c, lat);
        chk("sum_ff01", 0, s, 'h00);
        chk("cout_ff01", 0, c, 1);

        wait_idle(0);
        av[0] = 13'h0FF;
        bv[0] = 13'h0FF;
        st[0] = 1'b1;
        nd = 0;
        last = -1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (done8) begin
                nd++;
                if (last >= 0) chk("held_interval", 0, j - last, 10);
                last = j;
                chk("held_sum", 0, 32'(s8), 'hFE);
                chk("held_cout", 0, 32'(c8), 1);
            end
            if (busy8) begin
                av[0] = 13'($urandom);
                bv[0] = 13'($urandom);
            end else begin
                av[0] = 13'h0FF;
                bv[0] = 13'h0FF;
            end
        end
        st[0] = 1'b0;
        chk("held_count", 0, nd, 3);

        op(0, 'h12, 'h34, s, c, lat);
        chk("sum_1234", 0, s, 'h46);
        chk("cout_1234", 0, c, 0);
        wait_idle(0);
        av[0] = 13'h080;
        bv[0] = 13'h080;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 0, 32'(busy8), 32'(0));
        chk("abort_done", 0, 32'(done8), 32'(0));
        chk("abort_sum", 0, 32'(s8), 32'(0));
        chk("abort_cout", 0, 32'(c8), 32'(0));
        rst_n = 1'b1;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("abort_nodone", 0, nd, 0);
        op(0, 'h01, 'h01, s, c, lat);
        chk("sum_0101", 0, s, 'h02);
        chk("cout_0101", 0, c, 0);

        for (int p = 0; p < 4; p++) begin
            op(1, w1a[p], w1b[p], s, c, lat);
            chk("w1_result", 1, (c << 1) | s, w1e[p]);
            chk("w1_lat", 1, lat, 1);
        end

        fork
            rand_run(0);
            rand_run(2);
        join

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
